// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU sweep sequencer and its result buffer.
package alu_pkg;

  localparam int SEL_W     = 4;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/alu_result_buf.sv
// Result register file: synchronous write, registered read masked to 0 beyond count.
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  count,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the count mask hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < count) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/alu_sweep_seq.sv
// Steps the combinational alu through ALU_Sel codes first..last (mod 16), letting
// each settle for SETTLE_CYCLES before capturing ALU_Out into the result buffer.
module alu_sweep_seq
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEPTH         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [SEL_W-1:0]  sel_first,
  input  logic [SEL_W-1:0]  sel_last,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [SEL_W-1:0] first_q;
  logic [SEL_W-1:0] last_q;
  logic             wr_en;
  logic [SEL_W-1:0] wr_addr;

  assign wr_en   = (state == CAPTURE);
  // 4-bit subtraction gives the wrap-around index, so entry 0 is always the first code.
  assign wr_addr = ALU_Sel - first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      first_q    <= '0;
      last_q     <= '0;
      A          <= '0;
      B          <= '0;
      ALU_Sel    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            A          <= A_in;
            B          <= B_in;
            first_q    <= sel_first;
            last_q     <= sel_last;
            ALU_Sel    <= sel_first;
            count      <= '0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          count <= count + 5'd1;
          if (ALU_Sel == last_q) begin
            state <= DONE;
          end else begin
            ALU_Sel    <= ALU_Sel + 4'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_result_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(ALU_Out),
    .count  (count),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Directed bench for alu_sweep_seq with an A+B+ALU_Sel stub standing in for the alu.
module tb_alu_sweep_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] A_in, B_in;
  logic [3:0] sel_first, sel_last, rd_addr;
  logic [7:0] A, B, ALU_Out, rd_data;
  logic [3:0] ALU_Sel;
  logic       busy, done;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ALU_Out = A + B + {4'b0, ALU_Sel};

  alu_sweep_seq #(.SETTLE_CYCLES(2), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in),
    .sel_first(sel_first), .sel_last(sel_last), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .busy(busy), .done(done), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the accepting edge (cycle 0).
  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input logic [3:0] l);
    A_in = a; B_in = b; sel_first = f; sel_last = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic read_buf(input logic [3:0] addr, output logic [7:0] data);
    rd_addr = addr;
    step();
    data = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A_in = 8'h5A; B_in = 8'hA5;
    sel_first = 4'd3; sel_last = 4'd9; rd_addr = 4'd0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({A, B, ALU_Sel, busy, done, count, rd_data} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: A=%0d B=%0d sel=%0d busy=%b done=%b count=%0d rd=%0d, required all 0",
               A, B, ALU_Sel, busy, done, count, rd_data);
    end
  endtask

  task automatic test_basic();
    int done_at = -1;
    bit busy_ok = 1'b1;
    logic [7:0] d;
    launch(8'd10, 8'd2, 4'd1, 4'd5);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      step();
      if (done) done_at = k;
      else if (!busy) busy_ok = 1'b0;
    end
    n_checks++;
    if (done_at !== 16) begin
      n_fail++; $display("FAIL basic_latency: done at %0d, required 16", done_at);
    end
    n_checks++;
    if (busy_ok !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: continuous=%b at_done=%b, required 1/0", busy_ok, busy);
    end
    n_checks++;
    if (count !== 5'd5) begin
      n_fail++; $display("FAIL basic_count: got %0d, required 5", count);
    end
    for (int i = 0; i < 6; i++) begin
      read_buf(4'(i), d);
      n_checks++;
      if (d !== ((i < 5) ? 8'(13 + i) : 8'd0)) begin
        n_fail++; $display("FAIL basic_read[%0d]: got %0d, required %0d", i, d, (i < 5) ? 13 + i : 0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] codes [4];
    logic [7:0] vals [4];
    logic [7:0] d;
    int done_at = -1;
    codes = '{4'd14, 4'd15, 4'd0, 4'd1};
    vals  = '{8'd14, 8'd15, 8'd0, 8'd1};
    launch(8'hFF, 8'd1, 4'd14, 4'd1);
    n_checks++;
    if (ALU_Sel !== 4'd14) begin
      n_fail++; $display("FAIL wrap_sel[0]: got %0d, required 14", ALU_Sel);
    end
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      step();
      if (k <= 11) begin
        n_checks++;
        if (ALU_Sel !== codes[k/3]) begin
          n_fail++; $display("FAIL wrap_sel[%0d]: got %0d, required %0d", k, ALU_Sel, codes[k/3]);
        end
      end
      if (done) done_at = k;
    end
    n_checks++;
    if (done_at !== 13 || count !== 5'd4) begin
      n_fail++; $display("FAIL wrap_done: done at %0d count %0d, required 13 and 4", done_at, count);
    end
    for (int i = 0; i < 4; i++) begin
      read_buf(4'(i), d);
      n_checks++;
      if (d !== vals[i]) begin
        n_fail++; $display("FAIL wrap_read[%0d]: got %0d, required %0d", i, d, vals[i]);
      end
    end
  endtask

  task automatic test_single_full();
    int done_at = -1;
    logic [7:0] d;
    launch(8'd0, 8'd0, 4'd7, 4'd7);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      step();
      if (done) done_at = k;
    end
    n_checks++;
    if (done_at !== 4 || count !== 5'd1) begin
      n_fail++; $display("FAIL single_done: done at %0d count %0d, required 4 and 1", done_at, count);
    end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'd7) begin
      n_fail++; $display("FAIL single_read0: got %0d, required 7", d);
    end
    read_buf(4'd1, d);
    n_checks++;
    if (d !== 8'd0) begin
      n_fail++; $display("FAIL single_read1: got %0d, required 0", d);
    end

    done_at = -1;
    launch(8'd3, 8'd4, 4'd0, 4'd15);
    for (int k = 1; k <= 200 && done_at < 0; k++) begin
      step();
      if (done) done_at = k;
    end
    n_checks++;
    if (done_at !== 49 || count !== 5'd16) begin
      n_fail++; $display("FAIL full_done: done at %0d count %0d, required 49 and 16", done_at, count);
    end
    read_buf(4'd15, d);
    n_checks++;
    if (d !== 8'd22) begin
      n_fail++; $display("FAIL full_read15: got %0d, required 22", d);
    end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'd7) begin
      n_fail++; $display("FAIL full_read0: got %0d, required 7", d);
    end
  endtask

  task automatic test_ignored_start();
    int done_at = -1;
    bit busy_ok = 1'b1;
    logic [7:0] d;
    launch(8'd10, 8'd2, 4'd1, 4'd5);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      step();
      if (done) done_at = k;
      else if (!busy) busy_ok = 1'b0;
      if (k == 4) begin
        start = 1'b1; A_in = 8'd100; B_in = 8'd50; sel_first = 4'd0;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (done_at !== 16 || busy_ok !== 1'b1) begin
      n_fail++; $display("FAIL ignored_start_timing: done at %0d busy_cont=%b, required 16/1", done_at, busy_ok);
    end
    n_checks++;
    if (A !== 8'd10 || B !== 8'd2) begin
      n_fail++; $display("FAIL ignored_start_operands: A=%0d B=%0d, required 10/2", A, B);
    end
    for (int i = 0; i < 5; i++) begin
      read_buf(4'(i), d);
      n_checks++;
      if (d !== 8'(13 + i)) begin
        n_fail++; $display("FAIL ignored_start_read[%0d]: got %0d, required %0d", i, d, 13 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_at = -1;
    bit saw_done = 1'b0;
    logic [7:0] d;
    launch(8'd10, 8'd2, 4'd1, 4'd5);
    for (int k = 1; k <= 7; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 5'd0 || ALU_Sel !== 4'd0 || A !== 8'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: busy=%b count=%0d sel=%0d A=%0d done=%b, required all 0",
                         busy, count, ALU_Sel, A, done);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: done_seen=%b busy=%b, required 0/0", saw_done, busy);
    end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid_read0: got %0d, required 0", d);
    end
    launch(8'd10, 8'd2, 4'd1, 4'd5);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      step();
      if (done) done_at = k;
    end
    read_buf(4'd2, d);
    n_checks++;
    if (done_at !== 16 || count !== 5'd5 || d !== 8'd15) begin
      n_fail++; $display("FAIL reset_mid_restart: done at %0d count %0d read2 %0d, required 16/5/15",
                         done_at, count, d);
    end
  endtask

  task automatic test_reset_start();
    rst = 1'b1; start = 1'b1; A_in = 8'd55; sel_first = 4'd9; sel_last = 4'd9;
    step();
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || A !== 8'd0) begin
      n_fail++; $display("FAIL reset_start_edge: busy=%b A=%0d, required 0/0", busy, A);
    end
    step(); step();
    n_checks++;
    if (busy !== 1'b0 || ALU_Sel !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_idle: busy=%b sel=%0d done=%b, required 0/0/0", busy, ALU_Sel, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_single_full();
    test_ignored_start();
    test_reset_mid();
    test_reset_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sweep_seq.md
Name: alu_sweep_seq

Overview:
- Synthesizable sequencer that drives the team's 8-bit combinational `alu` across a contiguous range of ALU_Sel codes, one code at a time.
- After each code has settled, captures ALU_Out into a 16-entry result buffer. A host reads the buffer afterwards.
- Sits between a host or control FSM and `alu`: accepts a start request, drives A/B/ALU_Sel, and reports done plus a capture count.

Parameters:
- SETTLE_CYCLES, 2, cycles ALU_Sel is held before ALU_Out is captured (legal 1..15).
- DEPTH, 16, result buffer entries; one per possible ALU_Sel code (fixed 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- A_in  in  8  operand A, latched on accepted start.
- B_in  in  8  operand B, latched on accepted start.
- sel_first  in  4  first ALU_Sel code, latched on accepted start.
- sel_last  in  4  last ALU_Sel code, latched on accepted start.
- A  out  8  operand A to alu.
- B  out  8  operand B to alu.
- ALU_Sel  out  4  selection to alu.
- ALU_Out  in  8  result from alu.
- busy  out  1  high from the accepted start until the cycle before done.
- done  out  1  one-cycle pulse when the sweep completes.
- count  out  5  number of valid captured results (0..16).
- rd_addr  in  4  buffer read index.
- rd_data  out  8  buffer entry at rd_addr; registered, 1-cycle latency.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: A, B, ALU_Sel, busy, done, count and rd_data are 0; state is IDLE. Buffer contents are not cleared.
- States:
  - IDLE: on start=1, latch A_in, B_in, sel_first and sel_last. Set ALU_Sel=sel_first, count=0, busy=1, and go to SETTLE with settle counter = 0.
  - SETTLE: settle counter increments each cycle. When it reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE: write ALU_Out to buf[ALU_Sel - first_latched] and increment count.
    - If ALU_Sel == last_latched: go to DONE.
    - Otherwise: ALU_Sel <= ALU_Sel+1 (mod 16), reset the settle counter, and go to SETTLE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing per code: each ALU_Sel value is stable for SETTLE_CYCLES+1 cycles, and is captured on the final one.
- Total latency: start accepted at edge 0 → done high for N·(SETTLE_CYCLES+1)+1 cycles later. N = ((sel_last − sel_first) mod 16) + 1.
- Buffer indexing: the index is (ALU_Sel − sel_first) mod 16, so entry 0 is always the first code.
- Wrap-around: sel_last < sel_first wraps 15→0. Example: first=14, last=1 gives N=4, codes 14, 15, 0, 1.
- sel_first == sel_last: N=1.
- Full sweep: first=0, last=15 gives N=16 and count=16, encoded in 5 bits.
- start while busy or in DONE is ignored (no queueing). A start held high through DONE is accepted in the following IDLE cycle.
- A/B outputs hold the latched operands until the next accepted start. ALU_Sel holds its last code after DONE.
- rd_data: returns buf[rd_addr] if rd_addr < count, otherwise 0. The comparison uses the count value at the read edge.
- Reads during a sweep are allowed. Entries not yet captured read 0.
- rst mid-sweep: sequencer returns to IDLE next edge with all outputs at reset values. No done pulse; count=0, so all reads return 0.
- rst and start in the same cycle: reset wins.

Decomposition:
- Shared package `alu_pkg`:
  - state enum {IDLE, SETTLE, CAPTURE, DONE};
  - localparams SEL_W=4, DATA_W=8, BUF_DEPTH=16;
  - localparam CNT_W=5.
- One sub-module: `alu_result_buf`, a 16×8 register file with a synchronous write port and a registered read port with valid masking against count.
- FSM and counters live in the top module.

Test Plan:
Bench stub: ALU_Out = A + B + ALU_Sel (8-bit wrap), SETTLE_CYCLES=2.
- Basic sweep: A=10, B=2, first=1, last=5, start 1 cycle → done pulses 16 cycles after start; count=5; reads addr 0..4 = 13, 14, 15, 16, 17; addr 5 = 0.
- Wrap: A=8'hFF, B=1, first=14, last=1 → count=4; buf = 14, 15, 0, 1 (8-bit wrap of 0x100+sel); ALU_Sel sequence 14, 15, 0, 1, each held 3 cycles.
- Single and full sweeps:
  - first=last=7, A=B=0 → count=1, buf[0]=7, done 4 cycles after start.
  - first=0, last=15 → count=16, buf[15]=A+B+15.
- Ignored start: pulse start again mid-sweep with different A_in → no restart; results use the original operands; busy stays high continuously.
- Reset mid-sweep: assert rst for 1 cycle during the 3rd code → next cycle busy=0, count=0, ALU_Sel=0, no done pulse; a new start then completes normally.
- Reset and start coincide: rst=1 with start=1 → remains IDLE, busy=0.
